// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and Wishbone B3 constants for the two-master main-RAM arbiter.
package wb_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_e;

   localparam logic [2:0] CLASSIC = 3'b000;
   localparam logic [2:0] CONST   = 3'b001;
   localparam logic [2:0] INCR    = 3'b010;
   localparam logic [2:0] EOB     = 3'b111;

   localparam logic [1:0] LINEAR  = 2'b00;
   localparam logic [1:0] WRAP4   = 2'b01;
   localparam logic [1:0] WRAP8   = 2'b10;
   localparam logic [1:0] WRAP16  = 2'b11;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: pulses expire on the TIMEOUT-th consecutive unterminated strobe cycle.
module wb_arb_watchdog
   import wb_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic term,
   output logic expire
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_wd;
         assign unused_wd = clk ^ rst ^ active ^ term;
         assign expire    = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] count;

         // count holds completed stall cycles, so the current cycle is the
         // (count+1)-th stall; fire when that reaches TIMEOUT.
         assign expire = active && !term && (count == CW'(TIMEOUT - 1));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               count <= '0;
            end else if (!active || term || expire) begin
               count <= '0;
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter: OR1200 ibus (m0) and dbus (m1) onto one RAM slave.
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic [2:0]      m0_cti_i,
   input  logic [1:0]      m0_bte_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   output logic            m0_rty_o,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic [2:0]      m1_cti_i,
   input  logic [1:0]      m1_bte_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            m1_rty_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic [2:0]      s_cti_o,
   output logic [1:0]      s_bte_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   input  logic            s_rty_i,
   output logic [1:0]      dbg_state
);

   arb_state_e state, state_nxt;
   logic       last;
   logic       gnt_stb;
   logic       term;
   logic       expire;

   assign dbg_state = state;
   assign m0_dat_o  = s_dat_i;
   assign m1_dat_o  = s_dat_i;
   assign term      = s_ack_i | s_err_i | s_rty_i;
   assign gnt_stb   = ((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i);

   wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .active (gnt_stb),
      .term   (term),
      .expire (expire)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state_nxt == GNT0 && state != GNT0) begin
            last <= 1'b0;
         end else if (state_nxt == GNT1 && state != GNT1) begin
            last <= 1'b1;
         end
      end
   end

   // Grant is held for the whole cyc, so bursts are never split between masters.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_nxt = GNT0;
            else if (m1_cyc_i)        state_nxt = GNT1;
         end
         GNT0:    if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
         GNT1:    if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_cti_o  = '0;
      s_bte_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      case (state)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i && !expire;
            s_cti_o  = m0_cti_i;
            s_bte_o  = m0_bte_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | expire;
            m0_rty_o = s_rty_i;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i && !expire;
            s_cti_o  = m1_cti_i;
            s_bte_o  = m1_bte_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | expire;
            m1_rty_o = s_rty_i;
         end
         default: ;
      endcase
   end

endmodule
